// File: rtl/seletor_aprovados.sv
// Picks one approved slot, logs its predecessor, queues it for expansion.
// Round-robin arbitration when SELETOR_ROUND_ROBIN_EN is defined.
module seletor_aprovados #(
  parameter int NUM_NA          = 4,
  parameter int ADDR_WIDTH      = 5,
  parameter int DISTANCIA_WIDTH = 5,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            iniciar_in,
  input  logic [ADDR_WIDTH-1:0]           destino_in,
  input  logic [NUM_NA-1:0]               aa_aprovado_in,
  input  logic [ADDR_WIDTH*NUM_NA-1:0]    aa_endereco_in,
  input  logic [DISTANCIA_WIDTH*NUM_NA-1:0] aa_distancia_in,
  input  logic [ADDR_WIDTH*NUM_NA-1:0]    aa_anterior_data_in,
  input  logic                            aa_pronto_in,
  input  logic                            aa_ocupado_in,
  output logic                            sa_desativar_out,
  output logic [ADDR_WIDTH-1:0]           sa_endereco_out,
  output logic                            sa_mem_we_out,
  output logic [ADDR_WIDTH-1:0]           sa_mem_addr_out,
  output logic [ADDR_WIDTH-1:0]           sa_mem_data_out,
  output logic                            sa_valid_out,
  output logic [ADDR_WIDTH-1:0]           sa_exp_endereco_out,
  output logic [DISTANCIA_WIDTH-1:0]      sa_exp_distancia_out,
  input  logic                            expansor_ready_in,
  output logic                            sa_destino_out,
  output logic                            sa_ocupado_out
);

  localparam int IDX_W = (NUM_NA > 1) ? $clog2(NUM_NA) : 1;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int ENT_W = ADDR_WIDTH + DISTANCIA_WIDTH;

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] CAPTURA  = 3'd1;
  localparam logic [2:0] ESCRITA  = 3'd2;
  localparam logic [2:0] DESATIVA = 3'd3;
  localparam logic [2:0] ESPERA   = 3'd4;

  logic [2:0]                 state, state_n;
  logic [IDX_W-1:0]           sel_idx, idx_q;
  logic                       sel_ok;
  logic [ADDR_WIDTH-1:0]      addr_q;
  logic [DISTANCIA_WIDTH-1:0] dist_q;
  logic [ADDR_WIDTH-1:0]      cap_addr, cap_ant;
  logic [DISTANCIA_WIDTH-1:0] cap_dist;

  logic [ENT_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             full, push, pop;

  assign full = (cnt == CNT_W'(FIFO_DEPTH));
  assign push = (state == ESCRITA) && !iniciar_in;
  assign pop  = sa_valid_out && expansor_ready_in && !iniciar_in;

  assign cap_addr = aa_endereco_in[ADDR_WIDTH*idx_q +: ADDR_WIDTH];
  assign cap_ant  = aa_anterior_data_in[ADDR_WIDTH*idx_q +: ADDR_WIDTH];
  assign cap_dist = aa_distancia_in[DISTANCIA_WIDTH*idx_q +: DISTANCIA_WIDTH];

`ifdef SELETOR_ROUND_ROBIN_EN
  logic [IDX_W-1:0] rr_ptr;

  always_comb begin
    sel_idx = '0;
    sel_ok  = 1'b0;
    for (int k = 0; k < NUM_NA; k++) begin
      if (!sel_ok && aa_aprovado_in[(int'(rr_ptr) + k) % NUM_NA]) begin
        sel_ok  = 1'b1;
        sel_idx = IDX_W'((int'(rr_ptr) + k) % NUM_NA);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (state == IDLE && state_n == CAPTURA) begin
      rr_ptr <= (sel_idx == IDX_W'(NUM_NA - 1)) ? '0 : sel_idx + 1'b1;
    end
  end
`else
  always_comb begin
    sel_idx = '0;
    sel_ok  = |aa_aprovado_in;
    for (int k = NUM_NA - 1; k >= 0; k--) begin
      if (aa_aprovado_in[k]) sel_idx = IDX_W'(k);
    end
  end
`endif

  always_comb begin
    state_n = state;
    case (state)
      IDLE:
        if (sel_ok && aa_pronto_in && !aa_ocupado_in && !full)
          state_n = CAPTURA;
      CAPTURA:  state_n = ESCRITA;
      ESCRITA:  state_n = DESATIVA;
      DESATIVA: state_n = ESPERA;
      ESPERA:
        if (!aa_ocupado_in && !aa_aprovado_in[idx_q])
          state_n = IDLE;
      default:  state_n = IDLE;
    endcase
    if (iniciar_in) state_n = IDLE;
  end

  // Strobes are driven from state_n so they line up with their state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      idx_q            <= '0;
      addr_q           <= '0;
      dist_q           <= '0;
      sa_ocupado_out   <= 1'b0;
      sa_mem_we_out    <= 1'b0;
      sa_desativar_out <= 1'b0;
      sa_mem_addr_out  <= '0;
      sa_mem_data_out  <= '0;
      sa_endereco_out  <= '0;
      sa_destino_out   <= 1'b0;
    end else begin
      state            <= state_n;
      sa_ocupado_out   <= (state_n != IDLE);
      sa_mem_we_out    <= (state_n == ESCRITA);
      sa_desativar_out <= (state_n == DESATIVA);
      if (state == IDLE && state_n == CAPTURA) idx_q <= sel_idx;
      if (state_n == ESCRITA) begin
        addr_q          <= cap_addr;
        dist_q          <= cap_dist;
        sa_mem_addr_out <= cap_addr;
        sa_mem_data_out <= cap_ant;
      end
      if (state_n == DESATIVA) sa_endereco_out <= addr_q;
      if (iniciar_in) sa_destino_out <= 1'b0;
      else if (state == ESCRITA && addr_q == destino_in)
        sa_destino_out <= 1'b1;
    end
  end

  always_comb begin
    cnt_n = cnt;
    case ({push, pop})
      2'b10:   cnt_n = cnt + 1'b1;
      2'b01:   cnt_n = cnt - 1'b1;
      default: cnt_n = cnt;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {addr_q, dist_q};
  end

  // Head is kept in its own registers so the outputs stay flopped.
  always_ff @(posedge clk) begin
    if (rst || iniciar_in) begin
      rd_ptr               <= '0;
      wr_ptr               <= '0;
      cnt                  <= '0;
      sa_valid_out         <= 1'b0;
      sa_exp_endereco_out  <= '0;
      sa_exp_distancia_out <= '0;
    end else begin
      cnt          <= cnt_n;
      sa_valid_out <= (cnt_n != '0);
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && (cnt == '0 || (pop && cnt == CNT_W'(1)))) begin
        sa_exp_endereco_out  <= addr_q;
        sa_exp_distancia_out <= dist_q;
      end else if (pop && cnt > CNT_W'(1)) begin
        {sa_exp_endereco_out, sa_exp_distancia_out} <= mem[rd_ptr + 1'b1];
      end
    end
  end

endmodule

// File: tb/tb_seletor_aprovados.sv
// Directed + randomized bench for seletor_aprovados.
// Reference keeps expected queue, destination flag and arbitration pointer.
module tb_seletor_aprovados;

  localparam int N  = 4;
  localparam int AW = 5;
  localparam int DW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst, iniciar_in;
  logic [AW-1:0]   destino_in;
  logic [N-1:0]    aa_aprovado_in;
  logic [AW*N-1:0] aa_endereco_in, aa_anterior_data_in;
  logic [DW*N-1:0] aa_distancia_in;
  logic            aa_pronto_in, aa_ocupado_in;
  logic            sa_desativar_out, sa_mem_we_out;
  logic [AW-1:0]   sa_endereco_out, sa_mem_addr_out, sa_mem_data_out;
  logic            sa_valid_out;
  logic [AW-1:0]   sa_exp_endereco_out;
  logic [DW-1:0]   sa_exp_distancia_out;
  logic            expansor_ready_in, sa_destino_out, sa_ocupado_out;

  seletor_aprovados dut (
    .clk                  (clk),
    .rst                  (rst),
    .iniciar_in           (iniciar_in),
    .destino_in           (destino_in),
    .aa_aprovado_in       (aa_aprovado_in),
    .aa_endereco_in       (aa_endereco_in),
    .aa_distancia_in      (aa_distancia_in),
    .aa_anterior_data_in  (aa_anterior_data_in),
    .aa_pronto_in         (aa_pronto_in),
    .aa_ocupado_in        (aa_ocupado_in),
    .sa_desativar_out     (sa_desativar_out),
    .sa_endereco_out      (sa_endereco_out),
    .sa_mem_we_out        (sa_mem_we_out),
    .sa_mem_addr_out      (sa_mem_addr_out),
    .sa_mem_data_out      (sa_mem_data_out),
    .sa_valid_out         (sa_valid_out),
    .sa_exp_endereco_out  (sa_exp_endereco_out),
    .sa_exp_distancia_out (sa_exp_distancia_out),
    .expansor_ready_in    (expansor_ready_in),
    .sa_destino_out       (sa_destino_out),
    .sa_ocupado_out       (sa_ocupado_out)
  );

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  int checks = 0;
  int passed = 0;
  int failed = 0;

  logic [AW-1:0] s_addr [N];
  logic [AW-1:0] s_ant  [N];
  logic [DW-1:0] s_dist [N];
  ent_t          q [$];
  logic          exp_dest;
  int            rr;
  logic [N-1:0]  m;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive_slots();
    for (int i = 0; i < N; i++) begin
      aa_endereco_in[AW*i +: AW]      = s_addr[i];
      aa_anterior_data_in[AW*i +: AW] = s_ant[i];
      aa_distancia_in[DW*i +: DW]     = s_dist[i];
    end
  endtask

  task automatic rand_slots();
    for (int i = 0; i < N; i++) begin
      s_addr[i] = AW'($urandom);
      s_ant[i]  = AW'($urandom);
      s_dist[i] = DW'($urandom);
    end
    drive_slots();
  endtask

  task automatic pick(input logic [N-1:0] mk, output int idx);
    idx = -1;
`ifdef SELETOR_ROUND_ROBIN_EN
    for (int k = 0; k < N; k++)
      if (idx < 0 && mk[(rr + k) % N]) idx = (rr + k) % N;
    rr = (idx + 1) % N;
`else
    for (int k = N - 1; k >= 0; k--)
      if (mk[k]) idx = k;
`endif
  endtask

  task automatic check_head(input string tag);
    check({tag, "_valid"}, 32'(sa_valid_out), 32'(q.size() != 0));
    if (q.size() != 0) begin
      check({tag, "_haddr"}, 32'(sa_exp_endereco_out), 32'(q[0].a));
      check({tag, "_hdist"}, 32'(sa_exp_distancia_out), 32'(q[0].d));
    end
  endtask

  task automatic pop_one();
    expansor_ready_in = 1'b1;
    tick();
    expansor_ready_in = 1'b0;
    if (q.size() != 0) void'(q.pop_front());
    check_head("pop");
  endtask

  task automatic do_node(input logic [N-1:0] mk, input bit pp);
    int   idx;
    ent_t e;
    pick(mk, idx);
    aa_aprovado_in = mk;
    aa_pronto_in   = 1'b1;
    aa_ocupado_in  = 1'b0;
    tick();
    check("cap_busy", 32'(sa_ocupado_out), 32'd1);
    check("cap_we", 32'(sa_mem_we_out), 32'd0);
    tick();
    check("wr_we", 32'(sa_mem_we_out), 32'd1);
    check("wr_addr", 32'(sa_mem_addr_out), 32'(s_addr[idx]));
    check("wr_data", 32'(sa_mem_data_out), 32'(s_ant[idx]));
    if (pp) expansor_ready_in = 1'b1;
    tick();
    expansor_ready_in = 1'b0;
    check("des_stb", 32'(sa_desativar_out), 32'd1);
    check("des_addr", 32'(sa_endereco_out), 32'(s_addr[idx]));
    check("des_we", 32'(sa_mem_we_out), 32'd0);
    if (pp) void'(q.pop_front());
    e.a = s_addr[idx];
    e.d = s_dist[idx];
    q.push_back(e);
    if (s_addr[idx] == destino_in) exp_dest = 1'b1;
    check("dest", 32'(sa_destino_out), 32'(exp_dest));
    check_head("push");
    aa_ocupado_in = 1'b1;
    tick();
    check("esp_stb", 32'(sa_desativar_out), 32'd0);
    check("esp_busy", 32'(sa_ocupado_out), 32'd1);
    tick();
    check("esp_hold", 32'(sa_ocupado_out), 32'd1);
    aa_aprovado_in = mk & ~(N'(1) << idx);
    aa_ocupado_in  = 1'b0;
    aa_pronto_in   = 1'b0;
    tick();
    check("esp_rel", 32'(sa_ocupado_out), 32'd0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, 32'(sa_ocupado_out), 32'd0);
    check({tag, "_des"}, 32'(sa_desativar_out), 32'd0);
    check({tag, "_we"}, 32'(sa_mem_we_out), 32'd0);
    check({tag, "_dst"}, 32'(sa_destino_out), 32'd0);
    check({tag, "_val"}, 32'(sa_valid_out), 32'd0);
    check({tag, "_ea"}, 32'(sa_endereco_out), 32'd0);
    check({tag, "_ma"}, 32'(sa_mem_addr_out), 32'd0);
    check({tag, "_md"}, 32'(sa_mem_data_out), 32'd0);
    check({tag, "_ha"}, 32'(sa_exp_endereco_out), 32'd0);
    check({tag, "_hd"}, 32'(sa_exp_distancia_out), 32'd0);
  endtask

  initial begin
    rst                 = 1'b1;
    iniciar_in          = 1'b0;
    destino_in          = 5'd12;
    aa_aprovado_in      = '0;
    aa_endereco_in      = '0;
    aa_distancia_in     = '0;
    aa_anterior_data_in = '0;
    aa_pronto_in        = 1'b0;
    aa_ocupado_in       = 1'b0;
    expansor_ready_in   = 1'b0;
    exp_dest            = 1'b0;
    rr                  = 0;
    tick();
    tick();
    check_zero("rst");
    rst = 1'b0;
    tick();

    // single approved slot with fixed data
    rand_slots();
    s_addr[2] = 5'd9;
    s_ant[2]  = 5'd3;
    s_dist[2] = 5'd7;
    drive_slots();
    do_node(4'b0100, 1'b0);
    pop_one();

    // destination reached, then cleared by a new search
    rand_slots();
    s_addr[1] = 5'd12;
    drive_slots();
    do_node(4'b0010, 1'b0);
    iniciar_in = 1'b1;
    tick();
    iniciar_in = 1'b0;
    q.delete();
    exp_dest = 1'b0;
    check("ini_dest", 32'(sa_destino_out), 32'd0);
    check("ini_valid", 32'(sa_valid_out), 32'd0);
    check("ini_busy", 32'(sa_ocupado_out), 32'd0);

    // fill the queue, fifth node must wait for a pop
    for (int n = 0; n < 4; n++) begin
      rand_slots();
      do_node(N'($urandom_range(1, 15)), 1'b0);
    end
    rand_slots();
    m = N'($urandom_range(1, 15));
    aa_aprovado_in = m;
    aa_pronto_in   = 1'b1;
    for (int n = 0; n < 3; n++) begin
      tick();
      check("full_hold", 32'(sa_ocupado_out), 32'd0);
    end
    pop_one();
    check("full_pop_hold", 32'(sa_ocupado_out), 32'd0);
    do_node(m, 1'b0);
    for (int n = 0; n < 4; n++) pop_one();

    // push and pop together with one entry queued
    rand_slots();
    do_node(N'($urandom_range(1, 15)), 1'b0);
    rand_slots();
    do_node(N'($urandom_range(1, 15)), 1'b1);
    pop_one();

    // reset while the deactivate strobe is out
    rand_slots();
    m = N'($urandom_range(1, 15));
    aa_aprovado_in = m;
    aa_pronto_in   = 1'b1;
    tick();
    tick();
    tick();
    check("mid_des", 32'(sa_desativar_out), 32'd1);
    rst = 1'b1;
    tick();
    rst            = 1'b0;
    aa_pronto_in   = 1'b0;
    aa_aprovado_in = '0;
    q.delete();
    exp_dest = 1'b0;
    rr       = 0;
    check_zero("mrst");
    tick();
    check("mrst_idle", 32'(sa_ocupado_out), 32'd0);

    // two approved slots held across consecutive nodes
    rand_slots();
    s_addr[0] = 5'd20;
    s_addr[1] = 5'd21;
    drive_slots();
    do_node(4'b0011, 1'b0);
    do_node(4'b0011, 1'b0);
    pop_one();
    pop_one();

    // randomized traffic
    for (int n = 0; n < 10; n++) begin
      rand_slots();
      if (q.size() == 4) pop_one();
      do_node(N'($urandom_range(1, 15)), 1'b0);
      if ($urandom_range(0, 1) == 1) pop_one();
    end
    while (q.size() != 0) pop_one();
    pop_one();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/seletor_aprovados.md
SELETOR_APROVADOS -- requirements
Module: seletor_aprovados

Interface
REQ-001 Parameters, one per line:
- NUM_NA, default 4, number of active-node slots.
- ADDR_WIDTH, default 5, node address width.
- DISTANCIA_WIDTH, default 5, distance width.
- FIFO_DEPTH, default 4, power of 2, expansion queue depth.

REQ-002 Ports, one per line (name, direction, width, meaning):
- clk, in, 1, single clock; all logic rising-edge.
- rst, in, 1, synchronous active-high reset.
- iniciar_in, in, 1, new-search pulse; clears the destination flag.
- destino_in, in, ADDR_WIDTH, target node address.
- aa_aprovado_in, in, NUM_NA, per-slot approved flags from the evaluator.
- aa_endereco_in, in, ADDR_WIDTH*NUM_NA, slot addresses; slot i occupies bits [ADDR_WIDTH*i +: ADDR_WIDTH].
- aa_distancia_in, in, DISTANCIA_WIDTH*NUM_NA, slot distances, same packing.
- aa_anterior_data_in, in, ADDR_WIDTH*NUM_NA, slot predecessors, same packing.
- aa_pronto_in, in, 1, evaluator classification settled.
- aa_ocupado_in, in, 1, evaluator busy.
- sa_desativar_out, out, 1, one-cycle deactivate strobe to the evaluator.
- sa_endereco_out, out, ADDR_WIDTH, address to deactivate.
- sa_mem_we_out, out, 1, predecessor-memory write enable.
- sa_mem_addr_out, out, ADDR_WIDTH, predecessor-memory address.
- sa_mem_data_out, out, ADDR_WIDTH, predecessor-memory data.
- sa_valid_out, out, 1, expansion queue head valid.
- sa_exp_endereco_out, out, ADDR_WIDTH, head address.
- sa_exp_distancia_out, out, DISTANCIA_WIDTH, head distance.
- expansor_ready_in, in, 1, downstream pops the head when this and sa_valid_out are both 1.
- sa_destino_out, out, 1, sticky flag: destination node closed.
- sa_ocupado_out, out, 1, FSM not in IDLE.

Function
REQ-003 FSM states IDLE, CAPTURA, ESCRITA, DESATIVA, ESPERA; all outputs registered.
REQ-004 IDLE to CAPTURA when all four hold: |aa_aprovado_in, aa_pronto_in=1, aa_ocupado_in=0, queue not full. Otherwise the FSM stays in IDLE.
REQ-005 Slot select is combinational from aa_aprovado_in in IDLE; the index is latched on the IDLE to CAPTURA transition.
REQ-006 CAPTURA, 1 cycle: latch the selected slot's address, distance and predecessor, then go to ESCRITA.
REQ-007 ESCRITA, 1 cycle:
- sa_mem_we_out=1, addr = latched address, data = latched predecessor.
- Push {address, distance} into the queue.
- Go to DESATIVA.
REQ-008 DESATIVA, 1 cycle: sa_desativar_out=1 with sa_endereco_out = latched address, then go to ESPERA.
REQ-009 ESPERA: return to IDLE on the first cycle with aa_ocupado_in=0 and aa_aprovado_in[latched index]=0; hold in ESPERA indefinitely otherwise.
REQ-010 Latency from a qualifying IDLE cycle: write strobe at cycle +2, deactivate strobe at cycle +3, minimum 5 cycles per node.
REQ-011 Queue behaviour:
- FIFO_DEPTH entries; occupancy counter is $clog2(FIFO_DEPTH)+1 bits.
- Registered head; sa_valid_out rises the cycle after a push into an empty queue.
- Push and pop in the same cycle leave the count unchanged.
- A pop while empty is ignored.
- A push never occurs while full, guaranteed by REQ-004.
REQ-012 In ESCRITA, if the latched address equals destino_in, set sa_destino_out. The flag stays set until rst or iniciar_in.
REQ-013 iniciar_in flushes the queue, clears sa_destino_out and forces IDLE on the next cycle, taking priority over any transition. A strobe already issued is not retracted.
REQ-014 Address and data fields pass through unmodified; no arithmetic beyond the queue counters. Pointers wrap modulo FIFO_DEPTH.

Reset
REQ-015 rst=1 at a clock edge forces all of the following on the next cycle, from any state:
- FSM to IDLE.
- Queue empty; sa_valid_out=0.
- sa_desativar_out=0, sa_mem_we_out=0, sa_destino_out=0, sa_ocupado_out=0.
- All address and data outputs to 0.
- Round-robin pointer to 0.
REQ-016 Reset mid-operation abandons the node in flight with no partial write; rst has priority over iniciar_in.

Configuration
REQ-017 Macro SELETOR_ROUND_ROBIN_EN selects the slot arbitration:
- Defined: a rotating pointer starts at the slot after the last served slot and selects the first approved slot at or after the pointer, modulo NUM_NA.
- Undefined: the lowest-index approved slot always wins.

Verification
REQ-018 Bench scenarios:
- Single slot: aprovado=4'b0100, endereco slot2=5'd9, anterior=5'd3, distancia=5'd7 -> mem write addr 9 data 3 at cycle +2; desativar addr 9 at +3; queue head {9,7}.
- Back-to-back nodes, aprovado=4'b0011 held, ESPERA released for each slot in turn -> round-robin build serves slots 0 then 1; fixed-priority build serves slot 0 first.
- Queue full: 4 nodes pushed with expansor_ready_in=0, a fifth approved -> FSM holds in IDLE; one pop -> fifth node proceeds.
- Destination: destino_in=5'd12 and slot address 12 -> sa_destino_out=1 after ESCRITA; iniciar_in pulse -> flag 0 and queue empty.
- Reset asserted during DESATIVA -> next cycle all outputs 0, state IDLE, sa_valid_out=0.
- Simultaneous push and pop with count=1 -> count stays 1, head advances to the new entry.
